pipelined_mult: RTL and testbench
=================================

Name: pipelined_mult

Overview:
- Fully pipelined 64x64 unsigned integer multiplier returning the low 64 bits of the product.
- Start/done handshake; a new operation may be issued every cycle.
- Building block for the integer square-root unit, which issues multiplies and waits for done.
- Multiplier bits are consumed in equal-width slices, one slice per pipeline stage.

Parameters:
- NUM_STAGES, 8, number of pipeline stages. Legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64). Slice width is 64/NUM_STAGES bits (8 bits at the default).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears the pipeline.
- mcand  input  64  multiplicand, unsigned; sampled on the edge where start=1.
- mplier  input  64  multiplier, unsigned; sampled on the edge where start=1.
- start  input  1  issue request; each rising edge with start=1 and reset=0 launches one operation.
- product  output  64  (mcand*mplier) mod 2^64 for the operation completing; registered.
- done  output  1  high for exactly one cycle per completed operation; registered.

Behaviour:
- Reset (synchronous, active-high): on any rising edge with reset=1, all stage valid bits, done and product become 0.
  - start is ignored on reset edges; no operation launched during reset ever completes.
  - Reset mid-operation discards every in-flight operation; no done follows.
- Stage structure: each stage k holds valid, partial sum, shifted multiplicand, and remaining multiplier.
  - Stage 0 takes inputs directly from mcand, mplier and start, with a partial sum of 0.
- Per-stage operation, with W = 64/NUM_STAGES:
  - partial_sum_out = partial_sum_in + (mcand_in * mplier_in[W-1:0]), truncated to 64 bits.
  - mcand_out = mcand_in << W, truncated to 64 bits.
  - mplier_out = mplier_in >> W.
  - valid_out = valid_in.
  - Registered at each rising edge.
- Outputs: product and done are the registered partial sum and valid bit of the final stage.
- Latency: for an operation sampled at rising edge T, done=1 and product is correct after edge T+NUM_STAGES-1.
  - With the default of 8 stages this is after edge T+7, i.e. visible during the 8th cycle after issue.
  - done stays high for exactly one cycle.
- Throughput: one operation per cycle.
  - Back-to-back starts produce back-to-back done pulses, each with its own product, in issue order.
  - Operations never interfere with one another.
- Holding start high for N consecutive edges issues N operations, each using the operands present at its own edge.
- When done=0, product holds the final-stage register value; it is don't-care to the consumer but must be deterministic (never X after reset).
- Arithmetic is unsigned; overflow beyond bit 63 is discarded silently, with no carry or overflow flag.
- No input holding is required after the issue edge: operands are captured on that edge.

Test Plan:
- Reset with start=1, mcand=2, mplier=3 held through the reset edge. Then deassert reset, keeping start=1 for one further edge -> exactly one done pulse, 8 cycles after issue, with product=6. No done from the reset-cycle sample.
- mcand=5, mplier=50 -> product=250. mcand=0, mplier=257 -> product=0, with done still pulsing.
- mcand=FFFF_FFFF_FFFF_FFFF, mplier=FFFF_FFFF_FFFF_FFFF -> product=0000_0000_0000_0001. mcand=all-ones, mplier=3 -> product=FFFF_FFFF_FFFF_FFFD. mcand=all-ones, mplier=0 -> product=0.
- mcand=5555_5555_5555_5555, mplier=CCCC_CCCC_CCCC_CCCC -> product equals the low 64 bits of the true product.
  - Also 16 random 64-bit operand pairs, issued one at a time and each waited on done.
  - On every cycle with done=1, product must equal (mcand*mplier) mod 2^64 for that operation.
- Pipelining: issue 3 operations on consecutive edges (2*3, 7*9, all-ones*2) -> three consecutive done cycles with products 6, 63, FFFF_FFFF_FFFF_FFFE.
  - Then assert reset with 2 operations in flight -> no done pulses afterwards, and product=0.

Source files
------------

// File: rtl/pipelined_mult.sv
// Pipelined 64x64 unsigned multiplier, low 64 bits of the product.
// One multiplier slice of 64/NUM_STAGES bits is retired per stage.
module pipelined_mult #(
  parameter int NUM_STAGES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mcand,
  input  logic [63:0] mplier,
  input  logic        start,
  output logic [63:0] product,
  output logic        done
);

  localparam int W = 64 / NUM_STAGES;

  typedef struct packed {
    logic        valid;
    logic [63:0] psum;
    logic [63:0] mcand;
    logic [63:0] mplier;
  } stage_t;

  stage_t head;
  stage_t st [NUM_STAGES];

  function automatic stage_t step(input stage_t s);
    stage_t   r;
    logic [W-1:0] slice;
    slice    = s.mplier[W-1:0];
    r.valid  = s.valid;
    r.psum   = s.psum + (s.mcand * 64'(slice));
    r.mcand  = s.mcand << W;
    r.mplier = s.mplier >> W;
    return r;
  endfunction

  // Bubbles carry zeros so product stays deterministic when idle.
  always_comb begin
    head = '0;
    if (start) begin
      head.valid  = 1'b1;
      head.mcand  = mcand;
      head.mplier = mplier;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++)
        st[k] <= '0;
    end else begin
      st[0] <= step(head);
      for (int k = 1; k < NUM_STAGES; k++)
        st[k] <= step(st[k-1]);
    end
  end

  assign product = st[NUM_STAGES-1].psum;
  assign done    = st[NUM_STAGES-1].valid;

endmodule

// File: tb/tb_pipelined_mult.sv
// Bench for pipelined_mult: scoreboard of due cycles and products
// from a 128-bit reference multiply, checked every cycle.
module tb_pipelined_mult;

  localparam int NS = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] mcand = '0;
  logic [63:0] mplier = '0;
  logic        start = 1'b0;
  logic [63:0] product;
  logic        done;

  pipelined_mult #(.NUM_STAGES(NS)) dut (
    .clock  (clock),
    .reset  (reset),
    .mcand  (mcand),
    .mplier (mplier),
    .start  (start),
    .product(product),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  bit   armed = 0;

  function automatic logic [63:0] ref_mul(input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    return p[63:0];
  endfunction

  // Record each launched operation with the edge on which it must finish.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
    end else if (start) begin
      exp_t e;
      e.prod = ref_mul(mcand, mplier);
      e.due  = cyc + NS - 1;
      q.push_back(e);
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (armed) begin
      logic exp_d;
      exp_d = (q.size() > 0) && (q[0].due == cyc - 1);
      n_cmp++;
      assert (done === exp_d) else begin
        n_bad++;
        $error("FAIL done@%0d: got %b want %b", cyc, done, exp_d);
      end
      if (done === 1'b1) n_done++;
      if (exp_d) begin
        n_cmp++;
        assert (product === q[0].prod) else begin
          n_bad++;
          $error("FAIL product@%0d: got %h want %h",
                 cyc, product, q[0].prod);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic s);
    @(negedge clock);
    mcand  = a;
    mplier = b;
    start  = s;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #1;
    while (q.size() > 0 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    n_cmp++;
    assert (q.size() == 0) else begin
      n_bad++;
      $error("FAIL %s: timeout, %0d ops pending want 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic one(input logic [63:0] a, input logic [63:0] b,
                     input string tag);
    drive(a, b, 1'b1);
    drive('0, '0, 1'b0);
    wait_idle(tag);
  endtask

  initial begin
    int d0;
    mcand  = 64'd2;
    mplier = 64'd3;
    start  = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    assert (done === 1'b0) else begin
      n_bad++;
      $error("FAIL rst_done: got %b want 0", done);
    end
    n_cmp++;
    assert (product === 64'd0) else begin
      n_bad++;
      $error("FAIL rst_product: got %h want 0", product);
    end
    armed = 1;
    d0 = n_done;
    reset = 1'b0;
    drive('0, '0, 1'b0);
    wait_idle("first_op");
    repeat (3) @(negedge clock);
    n_cmp++;
    assert (n_done - d0 == 1) else begin
      n_bad++;
      $error("FAIL first_pulses: got %0d want 1", n_done - d0);
    end

    one(64'd5, 64'd50, "5x50");
    one(64'd0, 64'd257, "0x257");
    one('1, '1, "ones_x_ones");
    one('1, 64'd3, "ones_x3");
    one('1, 64'd0, "ones_x0");
    one(64'h5555_5555_5555_5555, 64'hCCCC_CCCC_CCCC_CCCC, "5x_cx");

    for (int i = 0; i < 16; i++)
      one({$urandom, $urandom}, {$urandom, $urandom}, "random");

    d0 = n_done;
    drive(64'd2, 64'd3, 1'b1);
    drive(64'd7, 64'd9, 1'b1);
    drive('1, 64'd2, 1'b1);
    drive('0, '0, 1'b0);
    wait_idle("pipe3");
    n_cmp++;
    assert (n_done - d0 == 3) else begin
      n_bad++;
      $error("FAIL pipe3_pulses: got %0d want 3", n_done - d0);
    end

    for (int i = 0; i < 6; i++)
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    drive('0, '0, 1'b0);
    wait_idle("burst");

    drive(64'd11, 64'd13, 1'b1);
    drive(64'd17, 64'd19, 1'b1);
    drive('0, '0, 1'b0);
    d0 = n_done;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    assert (product === 64'd0) else begin
      n_bad++;
      $error("FAIL flush_product: got %h want 0", product);
    end
    repeat (12) @(negedge clock);
    n_cmp++;
    assert (n_done - d0 == 0) else begin
      n_bad++;
      $error("FAIL flush_pulses: got %0d want 0", n_done - d0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
